// File: rtl/wave_gen_mc.sv
// ---------------------------------------------------------------------------
// wave_gen_mc -- multi-channel waveform generator behind a simple CPU bus.
//
// Each channel owns CTRL/PERIOD/AMPL registers and produces one OW-bit output
// in one of: OFF, TOGGLE, PWM, PRN (LFSR), SAW, TRI.
//
// Parameters
//   NCH  channel count (1..8)
//   OW   per-channel output width (4..16)
//
// Ports
//   clk     in   single clock, rising edge
//   resetn  in   asynchronous active-low reset
//   valid   in   bus request
//   ready   out  one-cycle acknowledge, the cycle after valid is accepted
//   wstrb   in   [3:0] any bit set = write, all zero = read
//   addr    in   [31:0] addr[6:4] channel, addr[3:2] register
//   wdata   in   [31:0] write data
//   rdata   out  [31:0] registered read data
//   wave    out  [NCH*OW-1:0] channel c at [c*OW +: OW]
//
// Register map per channel: 0 CTRL (mode[2:0]), 1 PERIOD[15:0],
// 2 AMPL[OW-1:0], 3 COUNT (read-only: accumulator in SAW/TRI, else counter).
//
// Configuration
//   WAVE_GEN_MC_PRN_EN  defined: mode 3 runs a 16-bit Fibonacci LFSR.
//                       absent:  no LFSR logic; mode 3 behaves as OFF.
// ---------------------------------------------------------------------------
module wave_gen_mc #(
    parameter int NCH = 4,
    parameter int OW  = 12
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              valid,
    output logic              ready,
    input  logic [3:0]        wstrb,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [NCH*OW-1:0] wave
);

    localparam logic [2:0] MODE_OFF    = 3'd0;
    localparam logic [2:0] MODE_TOGGLE = 3'd1;
    localparam logic [2:0] MODE_PWM    = 3'd2;
    localparam logic [2:0] MODE_PRN    = 3'd3;
    localparam logic [2:0] MODE_SAW    = 3'd4;
    localparam logic [2:0] MODE_TRI    = 3'd5;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PERIOD  = 2'd1;
    localparam logic [1:0] REG_AMPL    = 2'd2;
    localparam logic [1:0] REG_COUNT   = 2'd3;

    logic [2:0]    ctrl   [NCH];
    logic [15:0]   period [NCH];
    logic [OW-1:0] ampl   [NCH];
    logic [15:0]   cnt    [NCH];
    logic [OW-1:0] acc    [NCH];
    logic          tog    [NCH];
`ifdef WAVE_GEN_MC_PRN_EN
    // The seed keeps all 16 written bits so a full-width seed works even
    // when OW < 16; AMPL itself only stores OW bits.
    logic [15:0]   seed   [NCH];
    logic [15:0]   lfsr   [NCH];
`endif

    logic           accept;
    logic           is_write;
    logic [2:0]     ch_sel;
    logic [1:0]     reg_sel;
    logic [NCH-1:0] wr_hit;
    logic [NCH-1:0] wrap;
    logic [OW-1:0]  level  [NCH];
    logic [31:0]    rd_val;
    logic           unused_ok;

    // A request is taken only while ready is low, which makes ready a
    // one-cycle pulse and spaces back-to-back requests two cycles apart.
    assign accept   = valid & ~ready;
    // Byte strobes are not honoured individually: any set bit is a full write.
    assign is_write = |wstrb;
    assign ch_sel   = addr[6:4];
    assign reg_sel  = addr[3:2];
    assign unused_ok = ^{addr[31:7], addr[1:0], wdata[31:16]};

    // Out-of-range channels and COUNT never match, so they change nothing.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            wr_hit[c] = accept && is_write && (ch_sel == 3'(c)) && (reg_sel != REG_COUNT);
        end
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        rd_val = '0;
        for (int c = 0; c < NCH; c++) begin
            if (ch_sel == 3'(c)) begin
                case (reg_sel)
                    REG_CTRL:   rd_val = 32'(ctrl[c]);
                    REG_PERIOD: rd_val = 32'(period[c]);
                    REG_AMPL:   rd_val = 32'(ampl[c]);
                    default:    rd_val = (ctrl[c] == MODE_SAW || ctrl[c] == MODE_TRI)
                                         ? 32'(acc[c]) : 32'(cnt[c]);
                endcase
            end
        end
    end

    // Output level from the current state; registered below, giving one
    // cycle of latency from every state change.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            wrap[c]  = (cnt[c] >= period[c] - 16'd1);
            level[c] = '0;
            case (ctrl[c])
                MODE_TOGGLE: level[c] = tog[c] ? ampl[c] : '0;
                MODE_PWM:    level[c] = (cnt[c] < 16'(ampl[c])) ? {OW{1'b1}} : '0;
`ifdef WAVE_GEN_MC_PRN_EN
                MODE_PRN:    level[c] = lfsr[c][OW-1:0];
`else
                MODE_PRN:    level[c] = '0;
`endif
                MODE_SAW:    level[c] = acc[c];
                // Fold the doubled ramp back down in the upper half of the sweep.
                MODE_TRI:    level[c] = acc[c][OW-1] ? ~{acc[c][OW-2:0], 1'b0}
                                                     :  {acc[c][OW-2:0], 1'b0};
                default:     level[c] = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            ready <= 1'b0;
            rdata <= '0;
            wave  <= '0;
            // NOTE: the per-channel arrays are plain flops, not RAM, so each
            // element is cleared by the asynchronous reset.
            for (int c = 0; c < NCH; c++) begin
                ctrl[c]   <= MODE_OFF;
                period[c] <= 16'd2;
                ampl[c]   <= '0;
                cnt[c]    <= '0;
                acc[c]    <= '0;
                tog[c]    <= 1'b0;
`ifdef WAVE_GEN_MC_PRN_EN
                seed[c]   <= '0;
                lfsr[c]   <= 16'd1;
`endif
            end
        end else begin
            ready <= accept;
            if (accept && !is_write) begin
                rdata <= rd_val;
            end
            for (int c = 0; c < NCH; c++) begin
                wave[c*OW +: OW] <= wr_hit[c] ? '0 : level[c];
                if (wr_hit[c]) begin
                    // A register write restarts the channel and overrides
                    // any wrap happening on the same edge.
                    cnt[c] <= '0;
                    acc[c] <= '0;
                    tog[c] <= 1'b0;
`ifdef WAVE_GEN_MC_PRN_EN
                    lfsr[c] <= ((reg_sel == REG_AMPL) ? wdata[15:0] : seed[c]) | 16'd1;
`endif
                    case (reg_sel)
                        REG_CTRL:   ctrl[c]   <= wdata[2:0];
                        REG_PERIOD: period[c] <= (wdata[15:0] < 16'd2) ? 16'd2 : wdata[15:0];
                        default: begin
                            ampl[c] <= wdata[OW-1:0];
`ifdef WAVE_GEN_MC_PRN_EN
                            seed[c] <= wdata[15:0];
`endif
                        end
                    endcase
                end else begin
                    case (ctrl[c])
                        MODE_TOGGLE: begin
                            cnt[c] <= wrap[c] ? '0 : cnt[c] + 16'd1;
                            if (wrap[c]) tog[c] <= ~tog[c];
                        end
                        MODE_PWM: cnt[c] <= wrap[c] ? '0 : cnt[c] + 16'd1;
`ifdef WAVE_GEN_MC_PRN_EN
                        MODE_PRN: begin
                            cnt[c] <= wrap[c] ? '0 : cnt[c] + 16'd1;
                            // Fibonacci taps 16,14,13,11 feed bit 0.
                            if (wrap[c]) lfsr[c] <= {lfsr[c][14:0],
                                lfsr[c][15] ^ lfsr[c][13] ^ lfsr[c][12] ^ lfsr[c][10]};
                        end
`else
                        MODE_PRN: cnt[c] <= '0;
`endif
                        MODE_SAW, MODE_TRI: acc[c] <= acc[c] + ampl[c];
                        default: cnt[c] <= '0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_wave_gen_mc.sv
`timescale 1ns/1ps
module tb_wave_gen_mc;
    localparam int NCH   = 4;
    localparam int OW    = 12;
    localparam int OMASK = (1 << OW) - 1;

    logic              clk    = 1'b0;
    logic              resetn = 1'b0;
    logic              valid  = 1'b0;
    logic              ready;
    logic [3:0]        wstrb  = 4'h0;
    logic [31:0]       addr   = '0;
    logic [31:0]       wdata  = '0;
    logic [31:0]       rdata;
    logic [NCH*OW-1:0] wave;

    wave_gen_mc #(.NCH(NCH), .OW(OW)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .ready(ready),
        .wstrb(wstrb), .addr(addr), .wdata(wdata), .rdata(rdata), .wave(wave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: per-channel configuration plus the edge at which the
    // channel last restarted; outputs are closed-form functions of elapsed edges.
    int m_mode [NCH];
    int m_per  [NCH];
    int m_ampl [NCH];
    int m_seed [NCH];
    int m_start[NCH];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = 0; m_per[c] = 2; m_ampl[c] = 0; m_seed[c] = 0; m_start[c] = cyc;
        end
    endtask

`ifdef WAVE_GEN_MC_PRN_EN
    function automatic int prn_after(int seed, int shifts);
        int s;
        int fb;
        s = seed & 'hFFFF;
        for (int i = 0; i < shifts; i++) begin
            fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
            s  = ((s << 1) | fb) & 'hFFFF;
        end
        return s;
    endfunction
`endif

    // Output visible after edge n: zero at the restart edge, otherwise the
    // value for the state j = k-1 edges after restart.
    function automatic int model_wave(int c, int n);
        int k;
        int j;
        int a;
        k = n - m_start[c];
        if (k <= 0) return 0;
        j = k - 1;
        case (m_mode[c])
            1: return (((j / m_per[c]) % 2) == 1) ? m_ampl[c] : 0;
            2: return ((j % m_per[c]) < m_ampl[c]) ? OMASK : 0;
`ifdef WAVE_GEN_MC_PRN_EN
            3: return prn_after(m_seed[c] | 1, j / m_per[c]) & OMASK;
`endif
            4: return (j * m_ampl[c]) & OMASK;
            5: begin
                a = (j * m_ampl[c]) & OMASK;
                return (a >= (1 << (OW - 1))) ? (~(a * 2)) & OMASK : (a * 2) & OMASK;
            end
            default: return 0;
        endcase
    endfunction

    // COUNT value in the state reached after edge m.
    function automatic int model_count(int c, int m);
        int j;
        j = m - m_start[c];
        case (m_mode[c])
            1, 2: return j % m_per[c];
`ifdef WAVE_GEN_MC_PRN_EN
            3: return j % m_per[c];
`endif
            4, 5: return (j * m_ampl[c]) & OMASK;
            default: return 0;
        endcase
    endfunction

    function automatic int chan(int c);
        return int'(wave[c*OW +: OW]);
    endfunction

    // Compare process: every channel against the model, every cycle.
    logic prev_ready = 1'b0;
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("wave_ch%0d", c), 32'(wave[c*OW +: OW]), 32'(model_wave(c, cyc)));
        end
        check("ready_single", 32'(ready & prev_ready), 32'd0);
        prev_ready = ready;
    end

    task automatic bus_xfer(input int ch, input int rg, input logic wr,
                            input logic [31:0] data, output logic [31:0] rd);
        addr  = 32'((ch << 4) | (rg << 2));
        wstrb = wr ? 4'hF : 4'h0;
        wdata = data;
        valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (ready) break;
        end
        check($sformatf("ack_ch%0d_r%0d", ch, rg), 32'(ready), 32'd1);
        valid = 1'b0;
        wstrb = 4'h0;
        rd    = rdata;
    endtask

    task automatic bus_write(input int ch, input int rg, input logic [31:0] data);
        logic [31:0] dummy;
        int lo;
        bus_xfer(ch, rg, 1'b1, data, dummy);
        lo = int'(data & 32'hFFFF);
        if (ch < NCH && rg != 3) begin
            m_start[ch] = cyc;
            case (rg)
                0: m_mode[ch] = int'(data & 32'h7);
                1: m_per[ch]  = (lo < 2) ? 2 : lo;
                default: begin
                    m_ampl[ch] = lo & OMASK;
                    m_seed[ch] = lo;
                end
            endcase
        end
    endtask

    task automatic bus_read(input int ch, input int rg, output logic [31:0] rd);
        int exp;
        bus_xfer(ch, rg, 1'b0, 32'd0, rd);
        if (ch >= NCH) exp = 0;
        else case (rg)
            0: exp = m_mode[ch];
            1: exp = m_per[ch];
            2: exp = m_ampl[ch];
            default: exp = model_count(ch, cyc - 1);
        endcase
        check($sformatf("rd_ch%0d_r%0d", ch, rg), rd, 32'(exp));
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] rd;
    int t;
    int exp_a;
    int exp_b;

    initial begin
        model_reset();
        #12 resetn = 1'b1;
        @(posedge clk);
        #1;
        check("rst_wave_any", 32'(|wave), 32'd0);
        check("rst_ready",    32'(ready), 32'd0);
        check("rst_rdata",    rdata,      32'd0);
        bus_read(0, 1, rd); check("rst_period_lit", rd, 32'd2);
        bus_read(2, 0, rd); check("rst_ctrl_lit",   rd, 32'd0);

        // Toggle on ch0: period 4, full amplitude.
        bus_write(0, 1, 32'd4);
        bus_write(0, 2, 32'hFFF);
        bus_write(0, 0, 32'd1);
        t = cyc;
        bus_read(0, 3, rd); check("tog_count_a_lit", rd, 32'd1);
        bus_read(0, 3, rd); check("tog_count_b_lit", rd, 32'd3);
        wait_until(t + 5);  check("tog_high_lit", 32'(chan(0)), 32'hFFF);
        wait_until(t + 9);  check("tog_low_lit",  32'(chan(0)), 32'h000);
        wait_until(t + 13); check("tog_high2_lit", 32'(chan(0)), 32'hFFF);

        // PWM on ch1: 3 high of every 10.
        bus_write(1, 1, 32'd10);
        bus_write(1, 2, 32'd3);
        bus_write(1, 0, 32'd2);
        t = cyc;
        wait_until(t + 1);  check("pwm_hi_lit",  32'(chan(1)), 32'hFFF);
        wait_until(t + 4);  check("pwm_lo_lit",  32'(chan(1)), 32'h000);
        wait_until(t + 11); check("pwm_hi2_lit", 32'(chan(1)), 32'hFFF);
        bus_write(1, 2, 32'd0);
        t = cyc;
        wait_until(t + 12); check("pwm_zero_lit", 32'(chan(1)), 32'h000);
        bus_write(1, 2, 32'd10);
        t = cyc;
        wait_until(t + 1);  check("pwm_full_a_lit", 32'(chan(1)), 32'hFFF);
        wait_until(t + 10); check("pwm_full_b_lit", 32'(chan(1)), 32'hFFF);

        // Saw then triangle on ch2.
        bus_write(2, 2, 32'h100);
        bus_write(2, 0, 32'd4);
        t = cyc;
        wait_until(t + 2);  check("saw_step_lit", 32'(chan(2)), 32'h100);
        wait_until(t + 16); check("saw_top_lit",  32'(chan(2)), 32'hF00);
        wait_until(t + 17); check("saw_wrap_lit", 32'(chan(2)), 32'h000);
        bus_read(2, 3, rd);
        bus_write(2, 0, 32'd5);
        t = cyc;
        wait_until(t + 8);  check("tri_rise_lit", 32'(chan(2)), 32'hE00);
        wait_until(t + 17); check("tri_wrap_lit", 32'(chan(2)), 32'h000);
        bus_read(2, 3, rd);

        // PRN on ch3 (stays 0 when the LFSR is not built).
        bus_write(3, 1, 32'd2);
        bus_write(3, 2, 32'hACE0);
        bus_write(3, 0, 32'd3);
        t = cyc;
`ifdef WAVE_GEN_MC_PRN_EN
        exp_a = 'hCE1; exp_b = 'h9C3;
`else
        exp_a = 0; exp_b = 0;
`endif
        wait_until(t + 1); check("prn_seed_lit",  32'(chan(3)), 32'(exp_a));
        wait_until(t + 3); check("prn_shift_lit", 32'(chan(3)), 32'(exp_b));
        bus_read(3, 2, rd); check("prn_ampl_lit", rd, 32'hCE0);
        bus_read(3, 3, rd);

        // Register edge cases.
        bus_write(0, 1, 32'd0);          bus_read(0, 1, rd); check("per0_lit", rd, 32'd2);
        bus_write(0, 1, 32'd1);          bus_read(0, 1, rd); check("per1_lit", rd, 32'd2);
        bus_write(0, 0, 32'hFFFF_FFFF);  bus_read(0, 0, rd); check("ctrl7_lit", rd, 32'd7);
        bus_write(5, 0, 32'd1);
        bus_read(5, 0, rd); check("bad_ch_ctrl_lit", rd, 32'd0);
        bus_read(5, 1, rd); check("bad_ch_per_lit",  rd, 32'd0);
        bus_write(1, 3, 32'h55);
        bus_read(1, 0, rd); check("count_wr_ignored_lit", rd, 32'd2);
        bus_write(0, 0, 32'd1);
        repeat (6) @(posedge clk);
        #1;

        // Reset while a request is pending, ch1 in PWM at constant high.
        bus_read(1, 1, rd); check("pre_rst_rdata_lit", rdata, 32'd10);
        check("pre_rst_ready_lit", 32'(ready), 32'd1);
        check("pre_rst_wave_lit",  32'(chan(1)), 32'hFFF);
        addr  = 32'h0000_0010;
        wstrb = 4'h0;
        valid = 1'b1;
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        check("async_wave",  32'(|wave), 32'd0);
        check("async_ready", 32'(ready), 32'd0);
        check("async_rdata", rdata,      32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        bus_read(1, 0, rd); check("post_rst_ctrl_lit", rd, 32'd0);
        bus_read(1, 1, rd); check("post_rst_per_lit",  rd, 32'd2);
        repeat (4) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
